transfer_sequencer: RTL and testbench
=====================================

TRANSFER_SEQUENCER -- requirements
Module: transfer_sequencer

Interface
REQ-001 SHALL have parameter AW, default 8, address/word-count width.
REQ-002 SHALL have parameter TO_MAX, default 15, maximum cycles spent waiting for mem_ack.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 start  in  1  one-cycle request; sampled only in IDLE.
REQ-006 cfg_cr  in  3  control-register value for the transfer (bit0 selects word-counter mode, bit2 selects address direction: 0 = increment, 1 = decrement).
REQ-007 cfg_addr  in  AW  start address.
REQ-008 cfg_word  in  AW  word-register value.
REQ-009 cfg_len  in  AW  number of transfer beats.
REQ-010 abort  in  1  cancels an active transfer.
REQ-011 mem_ack  in  1  memory completed the current beat.
REQ-012 I  out  3  instruction to the instruction decoder.
REQ-013 data_bus  out  AW  value driven during load instructions; 0 otherwise.
REQ-014 mem_req  out  1  beat request to memory.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle pulse on successful completion.
REQ-017 err  out  1  one-cycle pulse on timeout or abort.
REQ-018 beats_left  out  AW  remaining beat count.

Function
REQ-019 SHALL use the instruction codes LD_CR=000, STATUS=001, LD_CNT=100, LD_AR=101, LD_WR=110 and STEP=111; STATUS is the idle code.
REQ-020 SHALL implement the states IDLE, LD_CR, LD_AR, LD_WR, LD_CNT, STEP_REQ, STEP_WAIT and FIN.
REQ-021 In IDLE with start=1, SHALL latch all cfg_* inputs and go to LD_CR on the next edge; start in any other state SHALL be ignored.
REQ-022 Each load state SHALL last exactly one cycle, in the order LD_CR -> LD_AR -> LD_WR -> LD_CNT.
REQ-023 Each load state SHALL drive its code on I and the latched value on data_bus: cr zero-extended in LD_CR, addr in LD_AR, word in LD_WR, len in LD_CNT.
REQ-024 From LD_CNT, SHALL go to FIN if len=0, otherwise to STEP_REQ.
REQ-025 In STEP_REQ, SHALL assert mem_req=1 with I=STATUS, and go to STEP_WAIT on the next edge.
REQ-026 In STEP_WAIT, SHALL hold mem_req=1 and I=STATUS until mem_ack is seen.
REQ-027 When mem_ack=1 in STEP_WAIT, SHALL drive I=STEP for exactly that cycle, decrement beats_left, and go to FIN if beats_left was 1, otherwise to STEP_REQ.
REQ-028 One STEP SHALL be issued per acknowledged beat; a STEP SHALL never be issued without mem_ack.
REQ-029 SHALL reset the timeout counter on entry to STEP_WAIT and increment it each cycle without mem_ack.
REQ-030 When the timeout counter reaches TO_MAX, SHALL pulse err and go to IDLE with mem_req deasserted.
REQ-031 FIN SHALL last one cycle, pulse done and return to IDLE.
REQ-032 abort=1 in any non-IDLE state other than FIN SHALL pulse err next cycle and force IDLE, with no further STEP issued.
REQ-033 abort in FIN SHALL be ignored and done SHALL still pulse.
REQ-034 If abort and mem_ack coincide in STEP_WAIT, abort SHALL win: no STEP, beats_left unchanged.
REQ-035 beats_left SHALL never wrap below 0.
REQ-036 Mid-operation start SHALL not relatch any configuration.
REQ-037 All outputs SHALL be registered-state decodes with no combinational path from inputs, except I=STEP and the beats_left update, which follow mem_ack in the same cycle.

Reset
REQ-038 On rst, SHALL enter IDLE and set I=001, data_bus=0, mem_req=0, busy=0, done=0, err=0, beats_left=0, and clear the timeout counter and latched configuration.
REQ-039 rst asserted mid-transfer SHALL take effect at the next edge, with no done or err pulse.

Structure
REQ-040 The state enum, instruction code constants and TO_MAX default SHALL reside in the shared package seq_pkg.
REQ-041 The timeout counter SHALL be one sub-module, seq_timeout (inputs clear and enable; output expired).

Verification
REQ-042 cfg_cr=001, addr=0x10, word=0x55, len=3, ack 2 cycles after each req -> I sequence 000,101,110,100, then three STEPs, done once, beats_left 3->0.
REQ-043 len=0 -> four load cycles, no mem_req, done on the cycle after LD_CNT.
REQ-044 len=2 with mem_ack never asserted -> err pulse after 15 wait cycles, IDLE, mem_req=0, beats_left=2.
REQ-045 abort coincident with the second mem_ack of len=4 -> exactly one STEP issued, err pulse, beats_left=3, busy=0 next cycle.
REQ-046 rst during LD_WR -> next cycle IDLE, I=001, no done or err; a new start then runs the full sequence correctly.
REQ-047 start held high during a transfer -> configuration unchanged; exactly one done for that transfer.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the transfer sequencer: FSM states, decoder
// instruction codes and the default wait-for-ack limit.
package seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LD_CR     = 3'd1,
        ST_LD_AR     = 3'd2,
        ST_LD_WR     = 3'd3,
        ST_LD_CNT    = 3'd4,
        ST_STEP_REQ  = 3'd5,
        ST_STEP_WAIT = 3'd6,
        ST_FIN       = 3'd7
    } seq_state_t;

    localparam logic [2:0] INSN_LD_CR  = 3'b000;
    localparam logic [2:0] INSN_STATUS = 3'b001;
    localparam logic [2:0] INSN_LD_CNT = 3'b100;
    localparam logic [2:0] INSN_LD_AR  = 3'b101;
    localparam logic [2:0] INSN_LD_WR  = 3'b110;
    localparam logic [2:0] INSN_STEP   = 3'b111;

    localparam int TO_MAX_DEFAULT = 15;

    // FIN always completes, so only the load and step states can be cancelled.
    function automatic logic is_abortable(input seq_state_t s);
        return (s != ST_IDLE) && (s != ST_FIN);
    endfunction

endpackage

// File: rtl/transfer_sequencer_if.sv
// Request/configuration inputs and decoder/memory outputs of the transfer
// sequencer, bundled so the controller and its environment share one port.
interface transfer_sequencer_if
    import seq_pkg::*;
#(
    parameter int AW = 8
);
    logic          start;
    logic [2:0]    cfg_cr;
    logic [AW-1:0] cfg_addr;
    logic [AW-1:0] cfg_word;
    logic [AW-1:0] cfg_len;
    logic          abort;
    logic          mem_ack;
    logic [2:0]    I;
    logic [AW-1:0] data_bus;
    logic          mem_req;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW-1:0] beats_left;

    modport master (
        output start, cfg_cr, cfg_addr, cfg_word, cfg_len, abort, mem_ack,
        input  I, data_bus, mem_req, busy, done, err, beats_left
    );

    modport slave (
        input  start, cfg_cr, cfg_addr, cfg_word, cfg_len, abort, mem_ack,
        output I, data_bus, mem_req, busy, done, err, beats_left
    );

endinterface

// File: rtl/seq_timeout.sv
// Wait-for-ack watchdog: counts non-acknowledged wait cycles and flags the
// cycle whose increment would bring the count to TO_MAX.
module seq_timeout
    import seq_pkg::*;
#(
    parameter int TO_MAX = TO_MAX_DEFAULT
)(
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int TW = (TO_MAX < 2) ? 1 : $clog2(TO_MAX + 1);

    logic [TW-1:0] r_count;

    // Wait-cycle counter, saturating at TO_MAX.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= {TW{1'b0}};
        end else if (clear) begin
            r_count <= {TW{1'b0}};
        end else if (enable && (r_count != TW'(TO_MAX))) begin
            r_count <= r_count + TW'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign expired = enable && (r_count == TW'(TO_MAX - 1));

endmodule

// File: rtl/transfer_sequencer.sv
// Transfer sequencer: loads CR/AR/WR/CNT into the instruction decoder, then
// issues one STEP per acknowledged memory beat, with abort and ack timeout.
module transfer_sequencer
    import seq_pkg::*;
#(
    parameter int AW     = 8,
    parameter int TO_MAX = TO_MAX_DEFAULT
)(
    input logic                clk,
    input logic                rst,
    transfer_sequencer_if.slave bus
);

    seq_state_t    r_state;
    seq_state_t    w_next;
    logic [2:0]    r_cr;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] r_word;
    logic [AW-1:0] r_len;
    logic [AW-1:0] r_beats;
    logic          r_err;

    logic          w_latch;
    logic          w_step;
    logic          w_err_set;
    logic          w_to_clear;
    logic          w_to_enable;
    logic          w_expired;
    logic [2:0]    w_insn;
    logic [AW-1:0] w_data;

    assign w_to_clear  = (r_state != ST_STEP_WAIT);
    assign w_to_enable = (r_state == ST_STEP_WAIT) && !bus.mem_ack;

    seq_timeout #(
        .TO_MAX (TO_MAX)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_to_clear),
        .enable  (w_to_enable),
        .expired (w_expired)
    );

    // Next-state logic; abort is checked first so it beats a coincident ack.
    always_comb begin
        w_next    = r_state;
        w_latch   = 1'b0;
        w_step    = 1'b0;
        w_err_set = 1'b0;
        if (is_abortable(r_state) && bus.abort) begin
            w_next    = ST_IDLE;
            w_err_set = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        w_next  = ST_LD_CR;
                        w_latch = 1'b1;
                    end else begin
                        w_next = ST_IDLE;
                    end
                end
                ST_LD_CR:    w_next = ST_LD_AR;
                ST_LD_AR:    w_next = ST_LD_WR;
                ST_LD_WR:    w_next = ST_LD_CNT;
                ST_LD_CNT: begin
                    if (r_len == {AW{1'b0}}) begin
                        w_next = ST_FIN;
                    end else begin
                        w_next = ST_STEP_REQ;
                    end
                end
                ST_STEP_REQ: w_next = ST_STEP_WAIT;
                ST_STEP_WAIT: begin
                    if (bus.mem_ack) begin
                        w_step = 1'b1;
                        if (r_beats == AW'(1)) begin
                            w_next = ST_FIN;
                        end else begin
                            w_next = ST_STEP_REQ;
                        end
                    end else if (w_expired) begin
                        w_next    = ST_IDLE;
                        w_err_set = 1'b1;
                    end else begin
                        w_next = ST_STEP_WAIT;
                    end
                end
                ST_FIN:      w_next = ST_IDLE;
                default:     w_next = ST_IDLE;
            endcase
        end
    end

    // State, latched configuration, beat counter and error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cr    <= 3'b000;
            r_addr  <= {AW{1'b0}};
            r_word  <= {AW{1'b0}};
            r_len   <= {AW{1'b0}};
            r_beats <= {AW{1'b0}};
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= w_err_set;
            if (w_latch) begin
                r_cr    <= bus.cfg_cr;
                r_addr  <= bus.cfg_addr;
                r_word  <= bus.cfg_word;
                r_len   <= bus.cfg_len;
                r_beats <= bus.cfg_len;
            end else if (w_step && (r_beats != {AW{1'b0}})) begin
                r_beats <= r_beats - AW'(1);
            end else begin
                r_beats <= r_beats;
            end
        end
    end

    // Instruction and data-bus decode of the current state.
    always_comb begin
        w_insn = INSN_STATUS;
        w_data = {AW{1'b0}};
        case (r_state)
            ST_LD_CR: begin
                w_insn = INSN_LD_CR;
                w_data = AW'(r_cr);
            end
            ST_LD_AR: begin
                w_insn = INSN_LD_AR;
                w_data = r_addr;
            end
            ST_LD_WR: begin
                w_insn = INSN_LD_WR;
                w_data = r_word;
            end
            ST_LD_CNT: begin
                w_insn = INSN_LD_CNT;
                w_data = r_len;
            end
            ST_STEP_WAIT: begin
                if (w_step) begin
                    w_insn = INSN_STEP;
                end else begin
                    w_insn = INSN_STATUS;
                end
            end
            default: begin
                w_insn = INSN_STATUS;
                w_data = {AW{1'b0}};
            end
        endcase
    end

    assign bus.I          = w_insn;
    assign bus.data_bus   = w_data;
    assign bus.mem_req    = (r_state == ST_STEP_REQ) || (r_state == ST_STEP_WAIT);
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.done       = (r_state == ST_FIN);
    assign bus.err        = r_err;
    assign bus.beats_left = r_beats;

endmodule

// File: tb/tb_transfer_sequencer.sv
// Directed bench for transfer_sequencer: load sequence, beats, len=0,
// timeout, abort, mid-transfer reset and held start.
module tb_transfer_sequencer;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   done_cnt;
    int   err_cnt;
    int   step_cnt;

    transfer_sequencer_if #(.AW(8)) bus ();

    transfer_sequencer #(.AW(8), .TO_MAX(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse/strobe counters sampled on the active edge.
    always @(posedge clk) begin
        if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
        if (bus.err === 1'b1)  err_cnt  <= err_cnt + 1;
        if (bus.I === 3'b111)  step_cnt <= step_cnt + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_start(input logic [2:0] cr, input logic [7:0] a,
                               input logic [7:0] w, input logic [7:0] l);
        bus.start = 1'b1; bus.cfg_cr = cr; bus.cfg_addr = a;
        bus.cfg_word = w; bus.cfg_len = l;
        tick;
        bus.start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick; tick;
        rst = 1'b0;
        n_tests++;
        if (bus.I !== 3'b001 || bus.data_bus !== 8'h00) begin
            n_fail++; $display("FAIL reset_insn: I=%b data=%h expected 001/00", bus.I, bus.data_bus);
        end
        n_tests++;
        if ({bus.mem_req, bus.busy, bus.done, bus.err} !== 4'b0000 || bus.beats_left !== 8'h00) begin
            n_fail++; $display("FAIL reset_flags: req/busy/done/err=%b beats=%h expected 0000/00",
                                {bus.mem_req, bus.busy, bus.done, bus.err}, bus.beats_left);
        end
    endtask

    task automatic test_normal;
        int d0, s0;
        d0 = done_cnt; s0 = step_cnt;
        drive_start(3'b001, 8'h10, 8'h55, 8'd3);
        n_tests++;
        if (bus.I !== 3'b000 || bus.data_bus !== 8'h01 || bus.beats_left !== 8'd3) begin
            n_fail++; $display("FAIL norm_ld_cr: I=%b data=%h beats=%0d expected 000/01/3", bus.I, bus.data_bus, bus.beats_left);
        end
        tick;
        n_tests++;
        if (bus.I !== 3'b101 || bus.data_bus !== 8'h10) begin
            n_fail++; $display("FAIL norm_ld_ar: I=%b data=%h expected 101/10", bus.I, bus.data_bus);
        end
        tick;
        n_tests++;
        if (bus.I !== 3'b110 || bus.data_bus !== 8'h55) begin
            n_fail++; $display("FAIL norm_ld_wr: I=%b data=%h expected 110/55", bus.I, bus.data_bus);
        end
        tick;
        n_tests++;
        if (bus.I !== 3'b100 || bus.data_bus !== 8'h03 || bus.mem_req !== 1'b0) begin
            n_fail++; $display("FAIL norm_ld_cnt: I=%b data=%h req=%b expected 100/03/0", bus.I, bus.data_bus, bus.mem_req);
        end
        for (int b = 0; b < 3; b++) begin
            tick;
            bus.mem_ack = 1'b0;
            n_tests++;
            if (bus.mem_req !== 1'b1 || bus.I !== 3'b001 || bus.beats_left !== 8'(3 - b)) begin
                n_fail++; $display("FAIL norm_req%0d: req=%b I=%b beats=%0d expected 1/001/%0d", b, bus.mem_req, bus.I, bus.beats_left, 3 - b);
            end
            tick;
            n_tests++;
            if (bus.mem_req !== 1'b1 || bus.I !== 3'b001) begin
                n_fail++; $display("FAIL norm_wait%0d: req=%b I=%b expected 1/001", b, bus.mem_req, bus.I);
            end
            tick;
            bus.mem_ack = 1'b1;
            #1;
            n_tests++;
            if (bus.I !== 3'b111) begin
                n_fail++; $display("FAIL norm_step%0d: I=%b expected 111", b, bus.I);
            end
        end
        tick;
        bus.mem_ack = 1'b0;
        n_tests++;
        if (bus.done !== 1'b1 || bus.beats_left !== 8'd0 || bus.mem_req !== 1'b0) begin
            n_fail++; $display("FAIL norm_fin: done=%b beats=%0d req=%b expected 1/0/0", bus.done, bus.beats_left, bus.mem_req);
        end
        tick;
        n_tests++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || (done_cnt - d0) != 1 || (step_cnt - s0) != 3) begin
            n_fail++; $display("FAIL norm_end: busy=%b dones=%0d steps=%0d expected 0/1/3", bus.busy, done_cnt - d0, step_cnt - s0);
        end
    endtask

    task automatic test_len_zero;
        drive_start(3'b010, 8'h01, 8'h02, 8'd0);
        n_tests++;
        if (bus.I !== 3'b000 || bus.data_bus !== 8'h02 || bus.mem_req !== 1'b0) begin
            n_fail++; $display("FAIL len0_ld_cr: I=%b data=%h req=%b expected 000/02/0", bus.I, bus.data_bus, bus.mem_req);
        end
        tick; tick; tick;
        n_tests++;
        if (bus.I !== 3'b100 || bus.data_bus !== 8'h00 || bus.mem_req !== 1'b0) begin
            n_fail++; $display("FAIL len0_ld_cnt: I=%b data=%h req=%b expected 100/00/0", bus.I, bus.data_bus, bus.mem_req);
        end
        tick;
        bus.abort = 1'b1;
        n_tests++;
        if (bus.done !== 1'b1 || bus.mem_req !== 1'b0) begin
            n_fail++; $display("FAIL len0_fin: done=%b req=%b expected 1/0", bus.done, bus.mem_req);
        end
        tick;
        bus.abort = 1'b0;
        n_tests++;
        if (bus.err !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++; $display("FAIL len0_fin_abort: err=%b busy=%b done=%b expected 0/0/0", bus.err, bus.busy, bus.done);
        end
    endtask

    task automatic test_timeout;
        drive_start(3'b000, 8'h08, 8'h09, 8'd2);
        tick; tick; tick;
        tick;
        for (int c = 1; c <= 15; c++) begin
            tick;
            n_tests++;
            if (bus.mem_req !== 1'b1 || bus.err !== 1'b0 || bus.busy !== 1'b1) begin
                n_fail++; $display("FAIL to_wait%0d: req=%b err=%b busy=%b expected 1/0/1", c, bus.mem_req, bus.err, bus.busy);
            end
        end
        tick;
        n_tests++;
        if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.mem_req !== 1'b0 || bus.beats_left !== 8'd2) begin
            n_fail++; $display("FAIL to_expire: err=%b busy=%b req=%b beats=%0d expected 1/0/0/2", bus.err, bus.busy, bus.mem_req, bus.beats_left);
        end
        tick;
        n_tests++;
        if (bus.err !== 1'b0) begin
            n_fail++; $display("FAIL to_pulse: err=%b expected 0", bus.err);
        end
    endtask

    task automatic test_abort;
        int s0, d0;
        s0 = step_cnt; d0 = done_cnt;
        drive_start(3'b100, 8'h20, 8'hAA, 8'd4);
        tick; tick; tick;
        tick;
        tick;
        bus.mem_ack = 1'b1;
        #1;
        n_tests++;
        if (bus.I !== 3'b111) begin
            n_fail++; $display("FAIL abort_step1: I=%b expected 111", bus.I);
        end
        tick;
        bus.mem_ack = 1'b0;
        n_tests++;
        if (bus.beats_left !== 8'd3 || bus.mem_req !== 1'b1) begin
            n_fail++; $display("FAIL abort_req2: beats=%0d req=%b expected 3/1", bus.beats_left, bus.mem_req);
        end
        tick;
        bus.mem_ack = 1'b1; bus.abort = 1'b1;
        #1;
        n_tests++;
        if (bus.I !== 3'b001) begin
            n_fail++; $display("FAIL abort_wins: I=%b expected 001", bus.I);
        end
        tick;
        bus.mem_ack = 1'b0; bus.abort = 1'b0;
        n_tests++;
        if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.beats_left !== 8'd3 || bus.mem_req !== 1'b0) begin
            n_fail++; $display("FAIL abort_err: err=%b busy=%b beats=%0d req=%b expected 1/0/3/0", bus.err, bus.busy, bus.beats_left, bus.mem_req);
        end
        tick;
        n_tests++;
        if ((step_cnt - s0) != 1 || (done_cnt - d0) != 0 || bus.err !== 1'b0) begin
            n_fail++; $display("FAIL abort_counts: steps=%0d dones=%0d err=%b expected 1/0/0", step_cnt - s0, done_cnt - d0, bus.err);
        end
    endtask

    task automatic test_rst_mid;
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        drive_start(3'b001, 8'h30, 8'h66, 8'd1);
        tick; tick;
        n_tests++;
        if (bus.I !== 3'b110 || bus.data_bus !== 8'h66) begin
            n_fail++; $display("FAIL rst_ld_wr: I=%b data=%h expected 110/66", bus.I, bus.data_bus);
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        n_tests++;
        if (bus.I !== 3'b001 || bus.busy !== 1'b0 || bus.data_bus !== 8'h00 || bus.beats_left !== 8'd0) begin
            n_fail++; $display("FAIL rst_idle: I=%b busy=%b data=%h beats=%0d expected 001/0/00/0", bus.I, bus.busy, bus.data_bus, bus.beats_left);
        end
        tick;
        n_tests++;
        if ((done_cnt - d0) != 0 || (err_cnt - e0) != 0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_no_pulse: dones=%0d errs=%0d busy=%b expected 0/0/0", done_cnt - d0, err_cnt - e0, bus.busy);
        end
        drive_start(3'b101, 8'h40, 8'h77, 8'd1);
        n_tests++;
        if (bus.I !== 3'b000 || bus.data_bus !== 8'h05) begin
            n_fail++; $display("FAIL rst_re_cr: I=%b data=%h expected 000/05", bus.I, bus.data_bus);
        end
        tick;
        n_tests++;
        if (bus.I !== 3'b101 || bus.data_bus !== 8'h40) begin
            n_fail++; $display("FAIL rst_re_ar: I=%b data=%h expected 101/40", bus.I, bus.data_bus);
        end
        tick;
        n_tests++;
        if (bus.I !== 3'b110 || bus.data_bus !== 8'h77) begin
            n_fail++; $display("FAIL rst_re_wr: I=%b data=%h expected 110/77", bus.I, bus.data_bus);
        end
        tick;
        n_tests++;
        if (bus.I !== 3'b100 || bus.data_bus !== 8'h01) begin
            n_fail++; $display("FAIL rst_re_cnt: I=%b data=%h expected 100/01", bus.I, bus.data_bus);
        end
        tick; tick;
        bus.mem_ack = 1'b1;
        #1;
        n_tests++;
        if (bus.I !== 3'b111) begin
            n_fail++; $display("FAIL rst_re_step: I=%b expected 111", bus.I);
        end
        tick;
        bus.mem_ack = 1'b0;
        n_tests++;
        if (bus.done !== 1'b1 || bus.beats_left !== 8'd0) begin
            n_fail++; $display("FAIL rst_re_done: done=%b beats=%0d expected 1/0", bus.done, bus.beats_left);
        end
        tick;
    endtask

    task automatic test_start_held;
        int d0;
        d0 = done_cnt;
        bus.start = 1'b1; bus.cfg_cr = 3'b010; bus.cfg_addr = 8'h50;
        bus.cfg_word = 8'h88; bus.cfg_len = 8'd1;
        tick;
        bus.cfg_cr = 3'b111; bus.cfg_addr = 8'hFF; bus.cfg_word = 8'h11; bus.cfg_len = 8'd5;
        n_tests++;
        if (bus.data_bus !== 8'h02) begin
            n_fail++; $display("FAIL held_cr: data=%h expected 02", bus.data_bus);
        end
        tick;
        n_tests++;
        if (bus.data_bus !== 8'h50) begin
            n_fail++; $display("FAIL held_ar: data=%h expected 50", bus.data_bus);
        end
        tick;
        n_tests++;
        if (bus.data_bus !== 8'h88) begin
            n_fail++; $display("FAIL held_wr: data=%h expected 88", bus.data_bus);
        end
        tick;
        n_tests++;
        if (bus.data_bus !== 8'h01 || bus.beats_left !== 8'd1) begin
            n_fail++; $display("FAIL held_cnt: data=%h beats=%0d expected 01/1", bus.data_bus, bus.beats_left);
        end
        tick; tick;
        bus.mem_ack = 1'b1;
        tick;
        bus.mem_ack = 1'b0;
        bus.start = 1'b0;
        n_tests++;
        if (bus.done !== 1'b1 || bus.beats_left !== 8'd0) begin
            n_fail++; $display("FAIL held_fin: done=%b beats=%0d expected 1/0", bus.done, bus.beats_left);
        end
        tick; tick;
        n_tests++;
        if ((done_cnt - d0) != 1 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL held_one_done: dones=%0d busy=%b expected 1/0", done_cnt - d0, bus.busy);
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        done_cnt = 0; err_cnt = 0; step_cnt = 0;
        rst = 1'b1;
        bus.start = 1'b0; bus.cfg_cr = 3'b000; bus.cfg_addr = 8'h00;
        bus.cfg_word = 8'h00; bus.cfg_len = 8'h00;
        bus.abort = 1'b0; bus.mem_ack = 1'b0;
        test_reset;
        test_normal;
        test_len_zero;
        test_timeout;
        test_abort;
        test_rst_mid;
        test_start_held;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
